alu_registrada_seq: RTL and testbench

Parametrised successor of the board-level registered ALU: one WIDTH-bit switch bank plus a single step button loads operand A, operand B and the opcode in sequence, then executes and shows the result. A control FSM replaces the four per-register enable inputs. A shift-add multiplier runs over multiple cycles. The block generates Z/N/C/V flags and drives hex 7-segment displays for A, B and the result on WIDTH/4 digits each. It sits directly under the board top level, between the switches, buttons, displays and LEDs.

---
 rtl/alu_registrada_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_registrada_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_registrada_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_registrada_seq: button-stepped registered ALU with multi-cycle MUL,     |
// | Z/N/C/V flags and hex 7-segment displays for A, B and result.               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_registrada_seq #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       sw,
  input  logic                   btn_next,
  input  logic                   btn_clr,
  output logic [7*(WIDTH/4)-1:0] seg_a,
  output logic [7*(WIDTH/4)-1:0] seg_b,
  output logic [7*(WIDTH/4)-1:0] seg_s,
  output logic [3:0]             leds_op,
  output logic [3:0]             flags,
  output logic [2:0]             state_o,
  output logic                   busy
);

  localparam int NDIG = WIDTH / 4;
  localparam int SHW  = $clog2(WIDTH);
  localparam logic [SHW-1:0] C_CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] C_CNT_ONE  = SHW'(1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         nxt_sync_q, clr_sync_q;
  logic               nxt, clr;
  logic [WIDTH-1:0]   a_q, b_q, s_q;
  logic [3:0]         op_q, flags_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;
  logic               is_mul, exec_done;

  // Bits [1:0] synchronise; bit 2 is the previous sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_sync_q <= 3'b000;
      clr_sync_q <= 3'b000;
    end else begin
      nxt_sync_q <= {nxt_sync_q[1:0], btn_next};
      clr_sync_q <= {clr_sync_q[1:0], btn_clr};
    end
  end

  assign nxt = nxt_sync_q[1] & ~nxt_sync_q[2];
  assign clr = clr_sync_q[1] & ~clr_sync_q[2];

  assign is_mul    = (op_q == 4'd9);
  assign exec_done = (state_q == S_EXEC) && (!is_mul || (cnt_q == C_CNT_LAST));
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_A;
    end else begin
      case (state_q)
        S_A:     if (nxt) state_d = S_B;
        S_B:     if (nxt) state_d = S_OP;
        S_OP:    if (nxt) state_d = S_EXEC;
        S_EXEC:  if (exec_done) state_d = S_SHOW;
        S_SHOW:  if (nxt) state_d = S_A;
        default: state_d = S_A;
      endcase
    end
  end

  // Combinational ALU; shifts carry one extra bit to capture the last bit out.
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic signed [WIDTH:0] sra_w;
  logic [WIDTH-1:0]   res_d;
  logic               c_d, v_d;
  logic [3:0]         flags_d;

  assign sh    = b_q[SHW-1:0];
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign shl_w = {1'b0, a_q} << sh;
  assign shr_w = {a_q, 1'b0} >> sh;
  assign sra_w = $signed({a_q, 1'b0}) >>> sh;

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_q)
      4'd0: begin
        res_d = add_w[WIDTH-1:0];
        c_d   = add_w[WIDTH];
        v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd1: begin
        res_d = sub_w[WIDTH-1:0];
        c_d   = sub_w[WIDTH];
        v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd2: res_d = a_q & b_q;
      4'd3: res_d = a_q | b_q;
      4'd4: res_d = a_q ^ b_q;
      4'd5: res_d = ~a_q;
      4'd6: begin
        res_d = shl_w[WIDTH-1:0];
        c_d   = shl_w[WIDTH];
      end
      4'd7: begin
        res_d = shr_w[WIDTH:1];
        c_d   = shr_w[0];
      end
      4'd8: begin
        res_d = sra_w[WIDTH:1];
        c_d   = sra_w[0];
      end
      4'd9: begin
        res_d = acc_step[WIDTH-1:0];
        c_d   = |acc_step[2*WIDTH-1:WIDTH];
      end
      default: res_d = '0;
    endcase
    flags_d = {(res_d == '0), res_d[WIDTH-1], c_d, v_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      op_q     <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (clr) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      op_q     <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_A: if (nxt) a_q <= sw;
        S_B: if (nxt) b_q <= sw;
        S_OP: if (nxt) begin
          op_q     <= sw[3:0];
          mcand_q  <= {{WIDTH{1'b0}}, a_q};
          mplier_q <= b_q;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        S_EXEC: begin
          if (is_mul) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + C_CNT_ONE;
          end
          if (exec_done) begin
            s_q     <= res_d;
            flags_q <= flags_d;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    assign seg_a[7*k +: 7] = hex7(a_q[4*k +: 4]);
    assign seg_b[7*k +: 7] = hex7(b_q[4*k +: 4]);
    assign seg_s[7*k +: 7] = hex7(s_q[4*k +: 4]);
  end

  assign leds_op = op_q;
  assign flags   = flags_q;
  assign state_o = state_q;
  assign busy    = (state_q == S_EXEC);

endmodule
`default_nettype wire

// File: tb/tb_alu_registrada_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_registrada_seq: random and directed scoreboard bench for             |
// | alu_registrada_seq. Revision: 1.0                                           |
// +----------------------------------------------------------------------------+
module tb_alu_registrada_seq;

  localparam int W  = 8;
  localparam int ND = W / 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    sw;
  logic            btn_next, btn_clr;
  logic [7*ND-1:0] seg_a, seg_b, seg_s;
  logic [3:0]      leds_op, flags;
  logic [2:0]      state_o;
  logic            busy;

  alu_registrada_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
    .seg_a(seg_a), .seg_b(seg_b), .seg_s(seg_s), .leds_op(leds_op),
    .flags(flags), .state_o(state_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic [3:0]   fl;
    int           blen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  function automatic logic [7*ND-1:0] disp(input logic [W-1:0] v);
    logic [7*ND-1:0] r;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = glyph(v[4*k +: 4]);
    return r;
  endfunction

  // Reference model from the arithmetic definitions, using wide integers.
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t   e;
    longint r, sr;
    int     sh, sa, sb, c, v, s;
    sh = b % W;
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb = (b >= 2**(W-1)) ? b - 2**W : b;
    c = 0; v = 0; r = 0;
    case (op)
      0: begin r = a + b; c = (r >= 2**W); sr = sa + sb; v = (sr > 2**(W-1)-1 || sr < -(2**(W-1))); end
      1: begin r = a - b; c = (a < b);     sr = sa - sb; v = (sr > 2**(W-1)-1 || sr < -(2**(W-1))); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = longint'(a) * (longint'(1) << sh); c = (sh > 0) ? ((a >> (W - sh)) & 1) : 0; end
      7: begin r = a >> sh; c = (sh > 0) ? ((a >> (sh - 1)) & 1) : 0; end
      8: begin r = sa >>> sh; c = (sh > 0) ? ((a >> (sh - 1)) & 1) : 0; end
      9: begin r = longint'(a) * longint'(b); c = (r >= 2**W); end
      default: r = 0;
    endcase
    s    = int'(r & (2**W - 1));
    e.s  = W'(s);
    e.fl = {(s == 0), 1'((s >> (W-1)) & 1), 1'(c), 1'(v)};
    e.blen = (op == 9) ? W : 1;
    e.a  = W'(a);
    e.b  = W'(b);
    e.op = 4'(op);
    return e;
  endfunction

  // Monitor: measures busy length and checks the result on every S_EXEC->S_SHOW entry.
  int         busy_cnt = 0;
  logic [2:0] prev_st  = 3'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0;
      prev_st  = 3'd0;
    end else begin
      if (busy) busy_cnt++;
      if (prev_st == 3'd3 && state_o == 3'd4) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got seg_s %0h expected no result", seg_s);
        end else begin
          e = q.pop_front();
          check("seg_s",    32'(seg_s),   32'(disp(e.s)));
          check("flags",    32'(flags),   32'(e.fl));
          check("busy_len", 32'(busy_cnt), 32'(e.blen));
          check("seg_a",    32'(seg_a),   32'(disp(e.a)));
          check("seg_b",    32'(seg_b),   32'(disp(e.b)));
          check("leds_op",  32'(leds_op), 32'(e.op));
        end
        busy_cnt = 0;
      end else if (state_o != 3'd3) begin
        busy_cnt = 0;
      end
      prev_st = state_o;
    end
  end

  task automatic load_val(input int v);
    sw = W'(v);
    @(negedge clk) btn_next = 1'b1;
    repeat (5) @(negedge clk);
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int limit, input string nm);
    int n = 0;
    while (state_o != 3'(st) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(state_o), 32'(st));
  endtask

  // Opcode press; optionally a second press lands while the multiplier runs.
  task automatic op_phase(input int op, input bit dbl);
    sw = W'(op);
    @(negedge clk) btn_next = 1'b1;
    repeat (3) @(negedge clk);
    check("exec_entry", 32'(state_o), 32'd3);
    check("busy_exec", 32'(busy), 32'd1);
    if (dbl) begin
      @(negedge clk) btn_next = 1'b0;
      @(negedge clk) btn_next = 1'b1;
      repeat (2) @(negedge clk);
      btn_next = 1'b0;
    end else begin
      @(negedge clk);
      if (op != 9) check("show_latency", 32'(state_o), 32'd4);
      @(negedge clk) btn_next = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run_op(input int a, input int b, input int op);
    load_val(a);
    load_val(b);
    q.push_back(model(a, b, op));
    op_phase(op, 1'b0);
    wait_state(4, 40, "reach_show");
    load_val(0);
    check("back_to_a", 32'(state_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sw = '0; btn_next = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_flags", 32'(flags),   32'd0);
    check("rst_busy",  32'(busy),    32'd0);
    check("rst_seg_a", 32'(seg_a),   32'(disp('0)));
    check("rst_seg_b", 32'(seg_b),   32'(disp('0)));
    check("rst_seg_s", 32'(seg_s),   32'(disp('0)));
    check("rst_op",    32'(leds_op), 32'd0);

    run_op(8'h7F, 8'h01, 0);
    run_op(8'h05, 8'h07, 1);
    run_op(8'hFF, 8'hFF, 1);
    run_op(8'h81, 8'h01, 7);
    run_op(8'h81, 8'h01, 8);
    run_op(8'h81, 8'h08, 8);
    run_op(8'h81, 8'h08, 6);
    run_op(8'h40, 8'h03, 6);
    run_op(8'h12, 8'h10, 12);

    // MUL with a step press during the busy window.
    load_val(8'h12);
    load_val(8'h10);
    q.push_back(model(8'h12, 8'h10, 9));
    op_phase(9, 1'b1);
    wait_state(4, 40, "mul_show");
    repeat (6) @(negedge clk);
    check("mul_stays_show", 32'(state_o), 32'd4);
    load_val(0);

    // Clear during MUL.
    load_val(8'hA5);
    load_val(8'h3C);
    sw = W'(9);
    @(negedge clk) btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_clr = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_pre_state", 32'(state_o), 32'd3);
    @(negedge clk);
    check("clr_state", 32'(state_o), 32'd0);
    check("clr_busy",  32'(busy),    32'd0);
    check("clr_seg_s", 32'(seg_s),   32'(disp('0)));
    check("clr_seg_a", 32'(seg_a),   32'(disp('0)));
    check("clr_seg_b", 32'(seg_b),   32'(disp('0)));
    check("clr_flags", 32'(flags),   32'd0);
    btn_clr = 1'b0; btn_next = 1'b0;
    repeat (12) @(negedge clk);
    check("clr_idle", 32'(state_o), 32'd0);

    // Asynchronous reset during MUL.
    load_val(8'h5A);
    load_val(8'hC3);
    sw = W'(9);
    @(negedge clk) btn_next = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_busy",  32'(busy),    32'd0);
    check("arst_flags", 32'(flags),   32'd0);
    check("arst_seg_a", 32'(seg_a),   32'(disp('0)));
    check("arst_op",    32'(leds_op), 32'd0);
    btn_next = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Long press advances exactly once.
    sw = W'(8'h33);
    btn_next = 1'b1;
    repeat (100) @(negedge clk);
    check("hold_once", 32'(state_o), 32'd1);
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
    load_val(8'h0F);
    q.push_back(model(8'h33, 8'h0F, 4));
    op_phase(4, 1'b0);
    wait_state(4, 40, "hold_show");
    load_val(0);

    for (int i = 0; i < 24; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 15)));
    end

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
